// File: rtl/rm_pkg.sv
// Shared definitions for the random-modulo Benes key controllers.
//   rm_state_t   : key controller FSM encoding
//   RM_LFSR_TAPS : default Galois feedback mask for the key LFSR
//   RM_LFSR_SEED : default nonzero reset seed for the key LFSR
//   benes_cnt(n) : switch count of an n-wide Benes network, so a cache
//                  instantiation derives the control width from its width
package rm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GEN       = 2'd1,
    WAIT_IDLE = 2'd2
  } rm_state_t;

  localparam logic [31:0] RM_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] RM_LFSR_SEED = 32'h0000_0001;

  // An n-wide Benes network has 2*log2(n)-1 columns of n/2 switches:
  // n*log2(n) - n/2 control bits.
  function automatic int benes_cnt(input int n);
    int lg;
    lg = 0;
    for (int v = n; v > 1; v = v / 2) lg++;
    return n * lg - n / 2;
  endfunction

endpackage

// File: rtl/rm_benes_key_ctrl_if.sv
// Handshake and key bus between a cache and its Benes key controller.
//   reseed_req   : level request for a new key, held until reseed_done
//   seed_load_en : load seed_i into the key LFSR (honoured when idle)
//   seed_i       : software seed
//   cache_idle   : no lookups in flight, key swap allowed this cycle
//   control_o    : active key driving the Benes control input
//   reseed_busy  : a key is being generated or is waiting to commit
//   reseed_done  : one-cycle pulse with the first cycle of the new key
//   epoch_o      : key epoch, bumps on each commit
// master = cache side, slave = key controller.
interface rm_benes_key_ctrl_if #(
  parameter int LFSR_W  = 32,
  parameter int CNT     = 20,
  parameter int EPOCH_W = 4
);
  logic               reseed_req;
  logic               seed_load_en;
  logic [LFSR_W-1:0]  seed_i;
  logic               cache_idle;
  logic [CNT-1:0]     control_o;
  logic               reseed_busy;
  logic               reseed_done;
  logic [EPOCH_W-1:0] epoch_o;

  modport master (
    output reseed_req, seed_load_en, seed_i, cache_idle,
    input  control_o, reseed_busy, reseed_done, epoch_o
  );

  modport slave (
    input  reseed_req, seed_load_en, seed_i, cache_idle,
    output control_o, reseed_busy, reseed_done, epoch_o
  );
endinterface

// File: rtl/rm_lfsr.sv
// Galois LFSR used as the key bit source for random-modulo key controllers.
//   clk, reset : clock and asynchronous active-high reset (state <= SEED)
//   load_en    : load load_val (a zero value is replaced by SEED so the
//                register can never lock up at zero); wins over step_en
//   load_val   : value to load
//   step_en    : advance one step
//   bit_o      : current output bit (state bit 0, taken before the step)
//   state_o    : full register contents
module rm_lfsr
  import rm_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(RM_LFSR_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(RM_LFSR_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step_en,
  output logic              bit_o,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (load_en) begin
      lfsr_q <= (load_val == '0) ? SEED : load_val;
    end else if (step_en) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  assign bit_o   = lfsr_q[0];
  assign state_o = lfsr_q;

endmodule

// File: rtl/rm_benes_key_ctrl.sv
// Key controller for the L1 random-modulo Benes permutation network.
// Holds an active key (control_o) and a shadow key. A reseed request fills
// the shadow key from the LFSR one bit per cycle (first bit lands in bit 0),
// then waits for the cache to go idle and swaps the whole key in at once,
// bumping the epoch so the cache knows its contents used a stale mapping.
//   clk, reset : clock and asynchronous active-high reset (identity key)
//   bus        : slave side of rm_benes_key_ctrl_if
module rm_benes_key_ctrl
  import rm_pkg::*;
#(
  parameter int                N       = 8,
  parameter int                CNT     = benes_cnt(N),
  parameter int                LFSR_W  = 32,
  parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(RM_LFSR_TAPS),
  parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(RM_LFSR_SEED),
  parameter int                EPOCH_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  rm_benes_key_ctrl_if.slave  bus
);

  localparam int CNT_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CNT - 1);

  rm_state_t          state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT-1:0]     shadow;
  logic [CNT-1:0]     control;
  logic [EPOCH_W-1:0] epoch;
  logic               done;

  logic               lfsr_bit;
  logic [LFSR_W-1:0]  unused_lfsr_state;
  logic [CNT:0]       shift_w;

  // Seed loads are only honoured while idle so a key in progress is never
  // disturbed; a load and a request in the same idle cycle both take effect,
  // and the first key bit then comes from the new seed.
  rm_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load_en  (bus.seed_load_en && (state == IDLE)),
    .load_val (bus.seed_i),
    .step_en  (state == GEN),
    .bit_o    (lfsr_bit),
    .state_o  (unused_lfsr_state)
  );

  // New bit enters at the top and the register shifts right, so after CNT
  // steps the first bit sits in shadow[0]. Written this way to stay legal
  // for CNT == 1.
  assign shift_w = {lfsr_bit, shadow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shadow  <= '0;
      control <= '0;
      epoch   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A request still high during the done pulse belongs to the key
          // just committed.
          if (bus.reseed_req && !done) begin
            state   <= GEN;
            bit_cnt <= '0;
          end
        end
        GEN: begin
          shadow  <= shift_w[CNT:1];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (bus.cache_idle) begin
            control <= shadow;
            epoch   <= epoch + 1'b1;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.control_o   = control;
  assign bus.epoch_o     = epoch;
  assign bus.reseed_done = done;
  assign bus.reseed_busy = (state == GEN) || (state == WAIT_IDLE);

endmodule

// File: tb/tb_rm_benes_key_ctrl.sv
module tb_rm_benes_key_ctrl;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_lfsr;
  logic [19:0] key0;

  rm_benes_key_ctrl_if #(.LFSR_W(32), .CNT(20), .EPOCH_W(4)) bus ();

  rm_benes_key_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: Galois step and CNT-bit key assembly (bit i = i-th output).
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  task automatic model_key(output logic [19:0] k);
    k = '0;
    for (int i = 0; i < 20; i++) begin
      k[i]   = m_lfsr[0];
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bus.reseed_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    bus.reseed_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_lfsr = SEED;
    step();
  endtask

  task automatic test_reset();
    bus.reseed_req   = 1'b0;
    bus.seed_load_en = 1'b0;
    bus.seed_i       = '0;
    bus.cache_idle   = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.control_o !== 20'h0) begin bad++; $display("FAIL reset_control: got %0h want 0", bus.control_o); end
      total++;
      if (bus.epoch_o !== 4'd0) begin bad++; $display("FAIL reset_epoch: got %0d want 0", bus.epoch_o); end
      total++;
      if (bus.reseed_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.reseed_busy); end
      total++;
      if (bus.reseed_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.reseed_done); end
    end
  endtask

  task automatic test_latency();
    logic [19:0] k;
    model_key(k);
    key0 = k;
    bus.cache_idle = 1'b1;
    bus.reseed_req = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      total++;
      if (bus.reseed_busy !== 1'b1 || bus.reseed_done !== 1'b0) begin
        bad++; $display("FAIL lat_busy edge %0d: busy=%b done=%b want busy=1 done=0", e, bus.reseed_busy, bus.reseed_done);
      end
    end
    step();
    bus.reseed_req = 1'b0;
    total++;
    if (bus.reseed_done !== 1'b1 || bus.reseed_busy !== 1'b0) begin
      bad++; $display("FAIL lat_commit: done=%b busy=%b want done=1 busy=0", bus.reseed_done, bus.reseed_busy);
    end
    total++;
    if (bus.control_o[3:0] !== 4'b1011) begin bad++; $display("FAIL lat_key_low: got %b want 1011", bus.control_o[3:0]); end
    total++;
    if (bus.control_o !== k) begin bad++; $display("FAIL lat_key: got %0h want %0h", bus.control_o, k); end
    total++;
    if (bus.epoch_o !== 4'd1) begin bad++; $display("FAIL lat_epoch: got %0d want 1", bus.epoch_o); end
    step();
    total++;
    if (bus.reseed_done !== 1'b0 || bus.reseed_busy !== 1'b0) begin
      bad++; $display("FAIL lat_after: done=%b busy=%b want 0 0", bus.reseed_done, bus.reseed_busy);
    end
  endtask

  task automatic test_wait_idle();
    do_reset();
    bus.cache_idle = 1'b0;
    bus.reseed_req = 1'b1;
    step();
    for (int e = 1; e <= 39; e++) begin
      step();
      total++;
      if (bus.reseed_busy !== 1'b1 || bus.control_o !== 20'h0) begin
        bad++; $display("FAIL wait_hold edge %0d: busy=%b ctrl=%0h want 1 0", e, bus.reseed_busy, bus.control_o);
      end
    end
    bus.cache_idle = 1'b1;
    step();
    bus.reseed_req = 1'b0;
    total++;
    if (bus.reseed_done !== 1'b1 || bus.control_o !== key0) begin
      bad++; $display("FAIL wait_commit: done=%b ctrl=%0h want 1 %0h", bus.reseed_done, bus.control_o, key0);
    end
    total++;
    if (bus.epoch_o !== 4'd1) begin bad++; $display("FAIL wait_epoch: got %0d want 1", bus.epoch_o); end
    m_lfsr = SEED;
    for (int i = 0; i < 20; i++) m_lfsr = lfsr_next(m_lfsr);
    step();
  endtask

  task automatic test_seed();
    logic [19:0] k;
    bit ok;
    // Zero seed with simultaneous request: LFSR restarts from SEED.
    bus.seed_i       = 32'h0;
    bus.seed_load_en = 1'b1;
    bus.reseed_req   = 1'b1;
    step();
    bus.seed_load_en = 1'b0;
    m_lfsr = SEED;
    model_key(k);
    wait_done(ok);
    bus.reseed_req = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL seed_zero_timeout: got no done want done"); end
    total++;
    if (bus.control_o !== key0) begin bad++; $display("FAIL seed_zero_key: got %0h want %0h", bus.control_o, key0); end
    step();
    // Load mid-GEN is ignored.
    bus.reseed_req = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    bus.seed_i       = 32'hDEAD_BEEF;
    bus.seed_load_en = 1'b1;
    step();
    step();
    step();
    bus.seed_load_en = 1'b0;
    model_key(k);
    wait_done(ok);
    bus.reseed_req = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL seed_gen_timeout: got no done want done"); end
    total++;
    if (bus.control_o !== k) begin bad++; $display("FAIL seed_gen_key: got %0h want %0h", bus.control_o, k); end
    step();
    // Nonzero seed load while idle.
    bus.seed_i       = 32'h1234_5678;
    bus.seed_load_en = 1'b1;
    step();
    bus.seed_load_en = 1'b0;
    m_lfsr = 32'h1234_5678;
    model_key(k);
    bus.reseed_req = 1'b1;
    wait_done(ok);
    bus.reseed_req = 1'b0;
    total++;
    if (!ok || bus.control_o !== k) begin bad++; $display("FAIL seed_load_key: got %0h want %0h", bus.control_o, k); end
    step();
  endtask

  task automatic test_reset_mid_gen();
    bit ok;
    bus.reseed_req = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.control_o !== 20'h0) begin bad++; $display("FAIL rst_mid_control: got %0h want 0", bus.control_o); end
    total++;
    if (bus.epoch_o !== 4'd0) begin bad++; $display("FAIL rst_mid_epoch: got %0d want 0", bus.epoch_o); end
    total++;
    if (bus.reseed_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.reseed_busy); end
    bus.reseed_req = 1'b0;
    step();
    reset = 1'b0;
    m_lfsr = SEED;
    step();
    bus.reseed_req = 1'b1;
    wait_done(ok);
    bus.reseed_req = 1'b0;
    total++;
    if (!ok || bus.control_o !== key0) begin bad++; $display("FAIL rst_mid_rekey: got %0h want %0h", bus.control_o, key0); end
    total++;
    if (bus.epoch_o !== 4'd1) begin bad++; $display("FAIL rst_mid_rekey_epoch: got %0d want 1", bus.epoch_o); end
    for (int i = 0; i < 20; i++) m_lfsr = lfsr_next(m_lfsr);
    step();
  endtask

  task automatic test_back_to_back();
    logic [19:0] k;
    logic [3:0]  exp_ep;
    bit ok;
    do_reset();
    bus.cache_idle = 1'b1;
    for (int i = 0; i < 17; i++) begin
      model_key(k);
      exp_ep = 4'((i + 1) % 16);
      bus.reseed_req = 1'b1;
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_timeout %0d: got no done want done", i); end
      total++;
      if (bus.control_o !== k) begin bad++; $display("FAIL b2b_key %0d: got %0h want %0h", i, bus.control_o, k); end
      total++;
      if (bus.epoch_o !== exp_ep) begin bad++; $display("FAIL b2b_epoch %0d: got %0d want %0d", i, bus.epoch_o, exp_ep); end
      // Request still held across the done edge must not start another key.
      step();
      total++;
      if (bus.reseed_busy !== 1'b0 || bus.reseed_done !== 1'b0) begin
        bad++; $display("FAIL b2b_extra %0d: busy=%b done=%b want 0 0", i, bus.reseed_busy, bus.reseed_done);
      end
      bus.reseed_req = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.reseed_req   = 1'b0;
    bus.seed_load_en = 1'b0;
    bus.seed_i       = '0;
    bus.cache_idle   = 1'b1;
    m_lfsr = SEED;
    key0   = '0;
    test_reset();
    test_latency();
    test_wait_idle();
    test_seed();
    test_reset_mid_gen();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rm_benes_key_ctrl.md
Name: rm_benes_key_ctrl

Overview:
- Owns the control word driven into the L1 random-modulo Benes permutation network. Holds one active key and one shadow key.
- On a reseed request, generates a new CNT-bit key from a Galois LFSR into the shadow register, one bit per cycle. It then waits for the cache to report no lookups in flight and atomically swaps the shadow key into the active key.
- Bumps a key epoch so the owning cache knows its contents were indexed under a stale mapping.

Parameters:
- N, 8, Benes network width (power of 2, >=2)
- CNT, 20, Benes control bits; must equal the switch count for N (N=2:1, N=4:6, N=8:20, N=16:56)
- LFSR_W, 32, LFSR width
- TAPS, 32'h80200003, Galois feedback mask
- SEED, 32'h00000001, reset seed; also replaces any zero seed load (must be nonzero)
- EPOCH_W, 4, key epoch counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reseed_req  in  1  level request for a new key; held until reseed_done
- seed_load_en  in  1  load seed_i into the LFSR; honoured in IDLE only
- seed_i  in  LFSR_W  software seed
- cache_idle  in  1  no lookups in flight; the swap is allowed this cycle
- control_o  out  CNT  active key to the Benes control input
- reseed_busy  out  1  high in GEN and WAIT_IDLE
- reseed_done  out  1  one-cycle pulse, coincident with the first cycle the new control_o is visible
- epoch_o  out  EPOCH_W  increments on each key commit, wraps modulo 2^EPOCH_W

Behaviour:
- Reset values:
  - control_o = 0 (all switches straight = identity permutation)
  - lfsr = SEED, shadow = 0, bit counter = 0, epoch_o = 0
  - reseed_busy = 0, reseed_done = 0, state = IDLE
- LFSR step: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). The output bit is lfsr[0] before the step.
- States:
  - IDLE:
    - If seed_load_en: lfsr <= (seed_i==0 ? SEED : seed_i).
    - If reseed_req && !reseed_done: go to GEN, clear the bit counter.
    - If seed_load_en and reseed_req arrive in the same cycle, the seed loads and GEN starts on the same edge, so the first generated bit comes from the new seed.
  - GEN, each cycle:
    - shadow <= {lfsr[0], shadow[CNT-1:1]}
    - lfsr steps; the counter increments
    - After the CNT-th bit, go to WAIT_IDLE.
    - The first generated bit therefore lands in shadow[0].
  - WAIT_IDLE:
    - On the first cycle with cache_idle=1: control_o <= shadow, epoch_o <= epoch_o+1, reseed_done <= 1, go to IDLE.
    - Otherwise hold; no timeout.
- seed_load_en outside IDLE is ignored and the LFSR is left undisturbed.
- reseed_req held high in the cycle reseed_done=1 is ignored, so one request yields exactly one key. Requesters drop reseed_req on seeing reseed_done.
- The LFSR is not reset between reseeds; consecutive keys continue the sequence.
- Latency with cache_idle held at 1: request sampled at edge 0 -> GEN for cycles 1..CNT -> WAIT_IDLE at cycle CNT+1 -> control_o and reseed_done at cycle CNT+2 (22 for defaults).
- control_o changes only on a commit edge and is never partially updated.
- Asserting reset mid-GEN or mid-WAIT_IDLE discards the shadow key. All state returns to reset values, and control_o reverts to identity.
- epoch_o wraps from 2^EPOCH_W-1 to 0.

Decomposition:
- Package rm_pkg:
  - rm_state_t enum {IDLE, GEN, WAIT_IDLE}
  - RM_LFSR_TAPS and RM_LFSR_SEED constants
  - benes_cnt(N) function returning the control count, so the cache instantiation derives CNT rather than hard-coding it
- Sub-module rm_lfsr:
  - parameters LFSR_W, TAPS, SEED
  - ports: clk, reset, load_en, load_val, step_en, bit_o, state_o
  - reused by the L1D and L1I key controllers

Test Plan:
- Reset, then idle 10 cycles -> control_o=20'h0, epoch_o=0, reseed_busy=0, reseed_done=0 throughout.
- SEED=1, pulse-hold reseed_req with cache_idle=1 -> reseed_busy high cycles 1..21, reseed_done pulses at cycle 22, control_o[3:0]=4'b1011, epoch_o=1; full 20 bits match the reference LFSR model.
- Same request but cache_idle=0 until cycle 40 -> control_o stays 0 and reseed_busy stays high through cycle 40; commit visible at cycle 41.
- seed_load_en with seed_i=0 plus reseed_req in the same IDLE cycle -> LFSR uses SEED (32'h1), key equals the previous test's key; seed_load_en mid-GEN with seed_i=32'hDEADBEEF -> ignored, key unchanged versus the model.
- reset asserted at GEN cycle 10 -> control_o=0, epoch_o=0, reseed_busy=0 asynchronously; a following reseed produces the SEED=1 key again.
- 17 back-to-back reseeds -> epoch_o wraps 15->0, successive keys follow the continuous LFSR sequence, and reseed_req held through reseed_done never triggers an extra key.
